// File: rtl/incline_cond.sv
// Incline conditioner: clamps inertial incline samples to OUT_W bits and
// smooths them with a seeded exponential moving average.
module incline_cond #(
  parameter int IN_W      = 13,
  parameter int OUT_W     = 10,
  parameter int AVG_SHIFT = 4,
  parameter int WARMUP    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  incline,
  input  logic                    vld,
  input  logic                    clr,
  output logic signed [OUT_W-1:0] avg_out,
  output logic                    avg_vld,
  output logic                    sat_flag,
  output logic                    settled
);

  localparam int ACC_W = OUT_W + AVG_SHIFT;
  localparam int CNT_W = $clog2(WARMUP + 1);

  logic signed [OUT_W-1:0] s1;
  logic                    s1_sat;
  logic                    s1_vld;
  logic signed [ACC_W-1:0] accum;
  logic signed [ACC_W-1:0] next_accum;
  logic signed [ACC_W-1:0] s1_ext;
  logic [CNT_W-1:0]        count;

  logic [IN_W-OUT_W:0]     top;
  logic                    over;
  logic signed [OUT_W-1:0] clamped;

  // In range only when all bits above the output sign bit match it
  assign top  = incline[IN_W-1:OUT_W-1];
  assign over = !((&top) || !(|top));

  always_comb begin
    clamped = incline[OUT_W-1:0];
    if (over) begin
      clamped = incline[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  assign s1_ext = {{AVG_SHIFT{s1[OUT_W-1]}}, s1};

  // First sample after reset/clr seeds the average instead of ramping from 0
  always_comb begin
    if (count == '0) begin
      next_accum = {s1, {AVG_SHIFT{1'b0}}};
    end else begin
      next_accum = accum - (accum >>> AVG_SHIFT) + s1_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s1_sat   <= 1'b0;
      s1_vld   <= 1'b0;
      accum    <= '0;
      count    <= '0;
      avg_out  <= '0;
      avg_vld  <= 1'b0;
      sat_flag <= 1'b0;
      settled  <= 1'b0;
    end else if (clr) begin
      s1_vld  <= 1'b0;
      accum   <= '0;
      count   <= '0;
      avg_vld <= 1'b0;
      settled <= 1'b0;
    end else begin
      if (vld) begin
        s1     <= clamped;
        s1_sat <= over;
      end
      s1_vld  <= vld;
      avg_vld <= s1_vld;
      if (s1_vld) begin
        accum    <= next_accum;
        avg_out  <= next_accum[ACC_W-1:AVG_SHIFT];
        sat_flag <= s1_sat;
        if (count != CNT_W'(WARMUP)) begin
          count <= count + 1'b1;
        end
        settled <= (count >= CNT_W'(WARMUP - 1));
      end
    end
  end

endmodule

// File: tb/tb_incline_cond.sv
// Directed bench for incline_cond: clamp, EMA seeding, latency, warm-up,
// clr and mid-flight reset behaviour.
module tb_incline_cond;

  logic               clk;
  logic               rst;
  logic signed [12:0] incline;
  logic               vld;
  logic               clr;
  logic signed [9:0]  avg_out;
  logic               avg_vld;
  logic               sat_flag;
  logic               settled;

  int n_vec;
  int n_bad;
  int pulses;
  int prev;

  incline_cond dut (
    .clk      (clk),
    .rst      (rst),
    .incline  (incline),
    .vld      (vld),
    .clr      (clr),
    .avg_out  (avg_out),
    .avg_vld  (avg_vld),
    .sat_flag (sat_flag),
    .settled  (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int v);
    @(negedge clk);
    incline = 13'(v);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
  endtask

  // Sample the cycle in which the avg_vld pulse is due
  task automatic expect_out(input string tag, input int v, input int sat,
                            input int stl);
    @(negedge clk);
    check({tag, ".vld"}, int'(avg_vld), 1);
    check({tag, ".avg"}, int'(avg_out), v);
    check({tag, ".sat"}, int'(sat_flag), sat);
    check({tag, ".stl"}, int'(settled), stl);
  endtask

  task automatic do_clr;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    incline = '0;
    vld     = 1'b0;
    clr     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.avg", int'(avg_out), 0);
    check("rst.vld", int'(avg_vld), 0);
    check("rst.sat", int'(sat_flag), 0);
    check("rst.stl", int'(settled), 0);
    rst = 1'b0;

    // Single sample: nothing one clock after, pulse two clocks after
    send(100);
    check("lat1.vld", int'(avg_vld), 0);
    expect_out("first", 100, 0, 0);
    @(negedge clk);
    check("lat3.vld", int'(avg_vld), 0);

    // Seed at 0, then step to 160
    do_clr();
    send(0);
    expect_out("seed0", 0, 0, 0);
    send(160);
    expect_out("s160a", 10, 0, 0);
    send(160);
    expect_out("s160b", 19, 0, 0);
    send(160);
    expect_out("s160c", 28, 0, 0);
    send(160);
    expect_out("s160d", 36, 0, 0);

    // Clamp limits and their boundaries
    do_clr();
    send(4095);
    expect_out("hi_clamp", 511, 1, 0);
    send(511);
    expect_out("hi_edge", 511, 0, 0);
    send(512);
    expect_out("hi_over", 511, 1, 0);
    do_clr();
    send(-4096);
    expect_out("lo_clamp", -512, 1, 0);
    do_clr();
    send(-512);
    expect_out("lo_edge", -512, 0, 0);
    send(-513);
    expect_out("lo_over", -512, 1, 0);

    // Back-to-back samples: 16 pulses, settled only with the 16th
    do_clr();
    pulses = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (avg_vld) begin
        pulses++;
        check("warm.stl", int'(settled), int'(pulses == 16));
        check("warm.avg", int'(avg_out), 7);
      end else begin
        check("warm.gap", cyc >= 2 && cyc <= 17 ? 0 : 1, 1);
      end
      incline = 13'sd7;
      vld = (cyc < 16);
    end
    check("warm.pulses", pulses, 16);
    check("warm.final", int'(settled), 1);
    send(7);
    expect_out("warm.sat", 7, 0, 1);

    // clr the cycle after vld: sample dropped, avg_out held
    send(300);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr1.vld", int'(avg_vld), 0);
    check("clr1.stl", int'(settled), 0);
    check("clr1.hold", int'(avg_out), 7);
    @(negedge clk);
    check("clr1.vld2", int'(avg_vld), 0);

    // clr and vld together: clr wins
    @(negedge clk);
    clr = 1'b1;
    vld = 1'b1;
    incline = 13'sd200;
    @(negedge clk);
    clr = 1'b0;
    vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr2.vld", int'(avg_vld), 0);
    end
    send(50);
    expect_out("reseed", 50, 0, 0);

    // Reset while a sample is in flight
    send(300);
    rst = 1'b1;
    #1;
    check("rst2.avg", int'(avg_out), 0);
    check("rst2.stl", int'(settled), 0);
    @(negedge clk);
    rst = 1'b0;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      prev += int'(avg_vld);
    end
    check("rst2.nopulse", prev, 0);
    check("rst2.avg2", int'(avg_out), 0);
    check("rst2.sat", int'(sat_flag), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
